// File: rtl/mem_ctrl.sv
// mem_ctrl: sole master of the byte-wide unified RAM/IO port.
// Arbitrates between load/store-buffer requests (strict priority) and
// 4-byte instruction fetches, serialises each request into byte transfers,
// assembles/extends load data and returns a one-cycle ready pulse.
//
// Ports:
//   clk, rst (sync, active-low), rdy (global enable; low = freeze)
//   rollback_signal : misprediction flush (aborts an in-flight fetch only)
//   io_buffer_full  : stalls writes into the IO region (addr[17:16] == IO_ADDR_HI)
//   LSB side : ena/wr/optype/addr/data/totByte _from_lsb in; lsb_rdy, data_2lsb out
//              optype uses RV32 load funct3: LB=000 LH=001 LW=010 LBU=100 LHU=101
//   IC side  : ena_from_ic, addr_from_ic in; ic_rdy, inst_2ic out
//   RAM side : mem_din in (valid one cycle after mem_a); mem_dout, mem_a, mem_wr out
module mem_ctrl #(
  parameter logic [1:0] IO_ADDR_HI = 2'b11
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        rollback_signal,
  input  logic        io_buffer_full,
  input  logic        ena_from_lsb,
  input  logic        wr_from_lsb,
  input  logic [2:0]  optype_from_lsb,
  input  logic [31:0] addr_from_lsb,
  input  logic [31:0] data_from_lsb,
  input  logic [2:0]  totByte_from_lsb,
  output logic        lsb_rdy,
  output logic [31:0] data_2lsb,
  input  logic        ena_from_ic,
  input  logic [31:0] addr_from_ic,
  output logic        ic_rdy,
  output logic [31:0] inst_2ic,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr
);

  typedef enum logic [2:0] {IDLE, LS_RD, LS_WR, IF_RD, DONE} state_t;

  state_t      state;
  logic [2:0]  cnt;
  logic [31:0] base;
  logic [31:0] wdata;
  logic [2:0]  optype;
  logic [2:0]  tot;
  logic [31:0] buffer;

  logic [31:0] asm_word;
  logic [31:0] load_ext;
  logic [31:0] a_next;
  logic [2:0]  rd_len;
  logic        acc_stall;
  logic        cur_stall;

  // In read states cnt counts cycles spent in the state; the byte arriving
  // on mem_din belongs to the address driven one cycle earlier (index cnt-1).
  always_comb begin
    asm_word = buffer;
    case (cnt)
      3'd1:    asm_word[7:0]   = mem_din;
      3'd2:    asm_word[15:8]  = mem_din;
      3'd3:    asm_word[23:16] = mem_din;
      3'd4:    asm_word[31:24] = mem_din;
      default: ;
    endcase
  end

  always_comb begin
    load_ext = asm_word;
    case (optype[1:0])
      2'b00:   load_ext = optype[2] ? {24'b0, asm_word[7:0]}
                                    : {{24{asm_word[7]}}, asm_word[7:0]};
      2'b01:   load_ext = optype[2] ? {16'b0, asm_word[15:0]}
                                    : {{16{asm_word[15]}}, asm_word[15:0]};
      default: load_ext = asm_word;
    endcase
  end

  assign a_next    = base + {29'b0, cnt} + 32'd1;
  assign rd_len    = (state == IF_RD) ? 3'd4 : tot;
  assign acc_stall = (addr_from_lsb[17:16] == IO_ADDR_HI) && io_buffer_full;
  assign cur_stall = (base[17:16] == IO_ADDR_HI) && io_buffer_full;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      cnt       <= '0;
      base      <= '0;
      wdata     <= '0;
      optype    <= '0;
      tot       <= '0;
      buffer    <= '0;
      lsb_rdy   <= 1'b0;
      data_2lsb <= '0;
      ic_rdy    <= 1'b0;
      inst_2ic  <= '0;
      mem_dout  <= '0;
      mem_a     <= '0;
      mem_wr    <= 1'b0;
    end else if (rdy) begin
      case (state)
        IDLE: begin
          mem_wr <= 1'b0;
          if (ena_from_lsb) begin
            base   <= addr_from_lsb;
            wdata  <= data_from_lsb;
            optype <= optype_from_lsb;
            tot    <= totByte_from_lsb;
            cnt    <= '0;
            mem_a  <= addr_from_lsb;
            if (wr_from_lsb) begin
              mem_dout <= data_from_lsb[7:0];
              mem_wr   <= !acc_stall;
              state    <= LS_WR;
            end else begin
              state <= LS_RD;
            end
          end else if (ena_from_ic && !rollback_signal) begin
            base  <= addr_from_ic;
            cnt   <= '0;
            mem_a <= addr_from_ic;
            state <= IF_RD;
          end
        end

        LS_RD, IF_RD: begin
          if (state == IF_RD && rollback_signal) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            if (cnt != 3'd0) buffer <= asm_word;
            if (cnt == rd_len) begin
              if (state == IF_RD) begin
                ic_rdy   <= 1'b1;
                inst_2ic <= asm_word;
              end else begin
                lsb_rdy   <= 1'b1;
                data_2lsb <= load_ext;
              end
              cnt   <= '0;
              state <= DONE;
            end else begin
              if (cnt + 3'd1 < rd_len) mem_a <= a_next;
              cnt <= cnt + 3'd1;
            end
          end
        end

        LS_WR: begin
          // mem_wr registered high means byte cnt went out this cycle;
          // low means it was held back by the IO stall and is retried.
          if (mem_wr) begin
            if (cnt + 3'd1 == tot) begin
              mem_wr    <= 1'b0;
              lsb_rdy   <= 1'b1;
              data_2lsb <= '0;
              cnt       <= '0;
              state     <= DONE;
            end else begin
              cnt      <= cnt + 3'd1;
              mem_a    <= a_next;
              mem_dout <= wdata[15:8];
              wdata    <= {8'h00, wdata[31:8]};
              mem_wr   <= !cur_stall;
            end
          end else begin
            mem_wr <= !cur_stall;
          end
        end

        DONE: begin
          lsb_rdy <= 1'b0;
          ic_rdy  <= 1'b0;
          mem_wr  <= 1'b0;
          state   <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
module tb_mem_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        rdy = 1'b1;
  logic        rollback_signal = 1'b0;
  logic        io_buffer_full = 1'b0;
  logic        ena_from_lsb = 1'b0;
  logic        wr_from_lsb = 1'b0;
  logic [2:0]  optype_from_lsb = '0;
  logic [31:0] addr_from_lsb = '0;
  logic [31:0] data_from_lsb = '0;
  logic [2:0]  totByte_from_lsb = '0;
  logic        lsb_rdy;
  logic [31:0] data_2lsb;
  logic        ena_from_ic = 1'b0;
  logic [31:0] addr_from_ic = '0;
  logic        ic_rdy;
  logic [31:0] inst_2ic;
  logic [7:0]  mem_din = '0;
  logic [7:0]  mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;

  mem_ctrl #(.IO_ADDR_HI(2'b11)) dut (
    .clk(clk), .rst(rst), .rdy(rdy), .rollback_signal(rollback_signal),
    .io_buffer_full(io_buffer_full), .ena_from_lsb(ena_from_lsb),
    .wr_from_lsb(wr_from_lsb), .optype_from_lsb(optype_from_lsb),
    .addr_from_lsb(addr_from_lsb), .data_from_lsb(data_from_lsb),
    .totByte_from_lsb(totByte_from_lsb), .lsb_rdy(lsb_rdy), .data_2lsb(data_2lsb),
    .ena_from_ic(ena_from_ic), .addr_from_ic(addr_from_ic), .ic_rdy(ic_rdy),
    .inst_2ic(inst_2ic), .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a),
    .mem_wr(mem_wr)
  );

  always #5 clk = ~clk;

  // Byte RAM: read data valid one cycle after the address, writes on the edge.
  logic [7:0] ram [0:262143];
  always @(posedge clk) begin
    if (mem_wr) ram[mem_a[17:0]] <= mem_dout;
    mem_din <= ram[mem_a[17:0]];
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Per-run observation log
  logic [31:0] addr_log [0:31];
  logic [31:0] wa [0:15];
  logic [7:0]  wd [0:15];
  int          nwr, lsb_p, ic_p, lsb_cyc, ic_cyc, both_hi;
  logic [31:0] lsb_dat, ic_dat;

  // Runs n cycles from the current one (requests already driven), logging
  // outputs. Requesters drop ena the cycle after their ready pulse.
  // rb_at: raise rollback (and withdraw the fetch) in that cycle for one cycle.
  // io_rel: release io_buffer_full in that cycle. hold_at: rdy low for 2 cycles.
  task automatic watch(input int n, input int rb_at, input int io_rel, input int hold_at);
    nwr = 0; lsb_p = 0; ic_p = 0; lsb_cyc = 0; ic_cyc = 0;
    lsb_dat = 'x; ic_dat = 'x;
    for (int c = 1; c <= n; c++) begin
      tick();
      addr_log[c] = mem_a;
      if (mem_wr && nwr < 16) begin
        wa[nwr] = mem_a;
        wd[nwr] = mem_dout;
        nwr++;
      end
      if (lsb_rdy && ic_rdy) both_hi++;
      if (lsb_rdy) begin
        lsb_p++;
        if (lsb_cyc == 0) begin lsb_cyc = c; lsb_dat = data_2lsb; end
      end
      if (ic_rdy) begin
        ic_p++;
        if (ic_cyc == 0) begin ic_cyc = c; ic_dat = inst_2ic; end
      end
      if (lsb_cyc != 0 && c == lsb_cyc + 1) ena_from_lsb = 1'b0;
      if (ic_cyc != 0 && c == ic_cyc + 1) ena_from_ic = 1'b0;
      if (c == rb_at) begin rollback_signal = 1'b1; ena_from_ic = 1'b0; end
      if (c == rb_at + 1) rollback_signal = 1'b0;
      if (c == io_rel) io_buffer_full = 1'b0;
      if (c == hold_at) rdy = 1'b0;
      if (c == hold_at + 2) rdy = 1'b1;
    end
    ena_from_lsb = 1'b0;
    ena_from_ic  = 1'b0;
  endtask

  task automatic lsb_req(input logic wr, input logic [2:0] op, input logic [31:0] a,
                         input logic [31:0] d, input logic [2:0] n);
    ena_from_lsb = 1'b1; wr_from_lsb = wr; optype_from_lsb = op;
    addr_from_lsb = a; data_from_lsb = d; totByte_from_lsb = n;
  endtask

  initial begin
    both_hi = 0;
    for (int i = 0; i < 262144; i++) ram[i] = 8'h00;
    ram[18'h100] = 8'h78; ram[18'h101] = 8'h56; ram[18'h102] = 8'h34; ram[18'h103] = 8'h12;
    ram[18'h020] = 8'h80;
    ram[18'h024] = 8'h34; ram[18'h025] = 8'hF2;
    ram[18'h200] = 8'h13; ram[18'h201] = 8'h05; ram[18'h202] = 8'h00; ram[18'h203] = 8'h00;

    tick(); tick();
    chk("rst_lsb_rdy", {31'b0, lsb_rdy}, 32'd0);
    chk("rst_ic_rdy",  {31'b0, ic_rdy},  32'd0);
    chk("rst_mem_wr",  {31'b0, mem_wr},  32'd0);
    chk("rst_mem_a",   mem_a,            32'd0);
    chk("rst_data",    data_2lsb,        32'd0);
    rst = 1'b1;
    tick();

    // LW 0x100
    lsb_req(1'b0, 3'b010, 32'h100, 32'h0, 3'd4);
    watch(10, 0, 0, 0);
    for (int k = 0; k < 4; k++) chk("lw_addr", addr_log[k + 1], 32'h100 + k);
    chk("lw_rdy_cyc", lsb_cyc, 6);
    chk("lw_pulses",  lsb_p, 1);
    chk("lw_data",    lsb_dat, 32'h12345678);

    // LB / LBU / LH
    lsb_req(1'b0, 3'b000, 32'h20, 32'h0, 3'd1);
    watch(6, 0, 0, 0);
    chk("lb_rdy_cyc", lsb_cyc, 3);
    chk("lb_data", lsb_dat, 32'hFFFFFF80);
    lsb_req(1'b0, 3'b100, 32'h20, 32'h0, 3'd1);
    watch(6, 0, 0, 0);
    chk("lbu_data", lsb_dat, 32'h00000080);
    lsb_req(1'b0, 3'b001, 32'h24, 32'h0, 3'd2);
    watch(7, 0, 0, 0);
    chk("lh_rdy_cyc", lsb_cyc, 4);
    chk("lh_data", lsb_dat, 32'hFFFFF234);

    // SW 0xDEADBEEF to 0x40; ena still high in DONE must not restart it
    lsb_req(1'b1, 3'b010, 32'h40, 32'hDEADBEEF, 3'd4);
    watch(10, 0, 0, 0);
    chk("sw_nwr", nwr, 4);
    chk("sw_rdy_cyc", lsb_cyc, 5);
    chk("sw_pulses", lsb_p, 1);
    chk("sw_data_out", lsb_dat, 32'h0);
    chk("sw_a0", wa[0], 32'h40); chk("sw_d0", {24'b0, wd[0]}, 32'hEF);
    chk("sw_a1", wa[1], 32'h41); chk("sw_d1", {24'b0, wd[1]}, 32'hBE);
    chk("sw_a2", wa[2], 32'h42); chk("sw_d2", {24'b0, wd[2]}, 32'hAD);
    chk("sw_a3", wa[3], 32'h43); chk("sw_d3", {24'b0, wd[3]}, 32'hDE);
    lsb_req(1'b0, 3'b010, 32'h40, 32'h0, 3'd4);
    watch(10, 0, 0, 0);
    chk("sw_readback", lsb_dat, 32'hDEADBEEF);

    // SB to IO region with 3 stalled cycles
    lsb_req(1'b0, 3'b001, 32'h24, 32'h0, 3'd2);
    watch(7, 0, 0, 0);
    io_buffer_full = 1'b1;
    lsb_req(1'b1, 3'b000, 32'h30000, 32'h00000041, 3'd1);
    watch(9, 0, 3, 0);
    chk("io_nwr", nwr, 1);
    chk("io_addr", wa[0], 32'h30000);
    chk("io_byte", {24'b0, wd[0]}, 32'h41);
    chk("io_pulses", lsb_p, 1);
    chk("io_rdy_cyc", lsb_cyc, 5);
    chk("io_data_out", lsb_dat, 32'h0);

    // SW with rdy low for two cycles mid-transfer
    lsb_req(1'b1, 3'b010, 32'h50, 32'h11223344, 3'd4);
    watch(12, 0, 0, 2);
    chk("hold_rdy_cyc", lsb_cyc, 7);
    chk("hold_pulses", lsb_p, 1);
    lsb_req(1'b0, 3'b010, 32'h50, 32'h0, 3'd4);
    watch(10, 0, 0, 0);
    chk("hold_readback", lsb_dat, 32'h11223344);

    // Simultaneous LSB + fetch: LSB first, fetch after DONE
    lsb_req(1'b0, 3'b000, 32'h20, 32'h0, 3'd1);
    ena_from_ic = 1'b1; addr_from_ic = 32'h200;
    watch(14, 0, 0, 0);
    chk("arb_lsb_cyc", lsb_cyc, 3);
    chk("arb_lsb_data", lsb_dat, 32'hFFFFFF80);
    chk("arb_ic_cyc", ic_cyc, 10);
    chk("arb_ic_pulses", ic_p, 1);
    chk("arb_inst", ic_dat, 32'h00000513);

    // Rollback while fetch byte 2 is on the bus
    ena_from_ic = 1'b1; addr_from_ic = 32'h200;
    watch(4, 3, 0, 0);
    chk("rbf_addr2", addr_log[3], 32'h202);
    chk("rbf_ic_p", ic_p, 0);
    lsb_req(1'b0, 3'b000, 32'h20, 32'h0, 3'd1);
    watch(6, 0, 0, 0);
    chk("rbf_idle_lb_cyc", lsb_cyc, 3);
    chk("rbf_ic_p2", ic_p, 0);

    // Rollback during LW
    lsb_req(1'b0, 3'b010, 32'h100, 32'h0, 3'd4);
    watch(10, 2, 0, 0);
    chk("rbl_rdy_cyc", lsb_cyc, 6);
    chk("rbl_data", lsb_dat, 32'h12345678);

    chk("rdy_exclusive", both_hi, 0);

    // Reset mid-store
    lsb_req(1'b1, 3'b010, 32'h60, 32'hA5A5A5A5, 3'd4);
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("mrst_mem_wr",   {31'b0, mem_wr},  32'd0);
    chk("mrst_mem_a",    mem_a,            32'd0);
    chk("mrst_mem_dout", {24'b0, mem_dout}, 32'd0);
    chk("mrst_lsb_rdy",  {31'b0, lsb_rdy}, 32'd0);
    chk("mrst_ic_rdy",   {31'b0, ic_rdy},  32'd0);
    chk("mrst_data",     data_2lsb,        32'd0);
    chk("mrst_inst",     inst_2ic,         32'd0);
    ena_from_lsb = 1'b0;
    rst = 1'b1;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
